// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
//
// Producer side of the EX-stage operand-forwarding interface for a 5-stage
// RV32I pipeline. It shadows the destination info of the instructions that are
// in flight, and from that it produces:
//   - registered forward selects for the instruction now in EX
//     (0 = register file, 1 = WB result, 2 = MEM result; 3 is never driven)
//   - the load-use stall, the ID/EX bubble and the branch-redirect flush.
//
// Ports
//   i_clk, i_reset       clock (rising edge), asynchronous active-high reset
//   i_id_*               operand/destination description of the ID instruction
//   i_ex_redirect        taken branch/jump resolved in EX this cycle
//   o_forward_A/B        operand selects for the instruction in EX
//   o_stall_id           hold PC and IF/ID
//   o_bubble_idex        load ID/EX with a NOP
//   o_flush_ifid         kill IF/ID contents
//   o_stall_count        saturating count of load-use stall cycles
// -----------------------------------------------------------------------------
module hazard_forward_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs1_addr,
  input  logic [REG_AW-1:0] i_id_rs2_addr,
  input  logic              i_id_rs1_used,
  input  logic              i_id_rs2_used,
  input  logic [REG_AW-1:0] i_id_rd_addr,
  input  logic              i_id_rd_wren,
  input  logic              i_id_is_load,
  input  logic              i_ex_redirect,
  output logic [1:0]        o_forward_A,
  output logic [1:0]        o_forward_B,
  output logic              o_stall_id,
  output logic              o_bubble_idex,
  output logic              o_flush_ifid,
  output logic [CNT_W-1:0]  o_stall_count
);

  // Shadow slots. The WB stage never needs its own copy: by the time an
  // instruction reaches WB its consumer's select was already latched (as 1)
  // when that consumer left ID while the producer moved MEM->WB.
  logic              r_ex_valid;
  logic [REG_AW-1:0] r_ex_rd;
  logic              r_ex_wren;
  logic              r_ex_load;
  logic              r_mem_valid;
  logic [REG_AW-1:0] r_mem_rd;
  logic              r_mem_wren;

  logic [1:0]        r_forward_a;
  logic [1:0]        r_forward_b;
  logic [CNT_W-1:0]  r_stall_count;

  logic              w_ex_hit_rs1;
  logic              w_ex_hit_rs2;
  logic              w_mem_hit_rs1;
  logic              w_mem_hit_rs2;
  logic              w_luse;
  logic              w_stall;
  logic              w_bubble;
  logic              w_load_ex;
  logic [1:0]        w_fwd_a_next;
  logic [1:0]        w_fwd_b_next;

  // Hit: slot holds a real instruction writing a non-zero rd equal to r.
  assign w_ex_hit_rs1  = r_ex_valid  & r_ex_wren  & (r_ex_rd  != '0) & (r_ex_rd  == i_id_rs1_addr);
  assign w_ex_hit_rs2  = r_ex_valid  & r_ex_wren  & (r_ex_rd  != '0) & (r_ex_rd  == i_id_rs2_addr);
  assign w_mem_hit_rs1 = r_mem_valid & r_mem_wren & (r_mem_rd != '0) & (r_mem_rd == i_id_rs1_addr);
  assign w_mem_hit_rs2 = r_mem_valid & r_mem_wren & (r_mem_rd != '0) & (r_mem_rd == i_id_rs2_addr);

  assign w_luse = i_id_valid & r_ex_load &
                  ((i_id_rs1_used & w_ex_hit_rs1) | (i_id_rs2_used & w_ex_hit_rs2));

  // A redirect kills the ID instruction anyway, so it overrides the stall.
  assign w_stall   = w_luse & ~i_ex_redirect;
  assign w_bubble  = w_stall | i_ex_redirect;
  assign w_load_ex = i_id_valid & ~w_bubble;

  // The current EX occupant is the MEM producer next cycle, the current MEM
  // occupant is the WB producer; the younger one wins. A load in EX cannot
  // supply select 2 because its data only exists after MEM.
  always_comb begin
    w_fwd_a_next = 2'd0;
    w_fwd_b_next = 2'd0;
    if (i_id_rs1_used & w_ex_hit_rs1 & ~r_ex_load) begin
      w_fwd_a_next = 2'd2;
    end else if (i_id_rs1_used & w_mem_hit_rs1) begin
      w_fwd_a_next = 2'd1;
    end
    if (i_id_rs2_used & w_ex_hit_rs2 & ~r_ex_load) begin
      w_fwd_b_next = 2'd2;
    end else if (i_id_rs2_used & w_mem_hit_rs2) begin
      w_fwd_b_next = 2'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ex_valid    <= 1'b0;
      r_ex_rd       <= '0;
      r_ex_wren     <= 1'b0;
      r_ex_load     <= 1'b0;
      r_mem_valid   <= 1'b0;
      r_mem_rd      <= '0;
      r_mem_wren    <= 1'b0;
      r_forward_a   <= 2'd0;
      r_forward_b   <= 2'd0;
      r_stall_count <= '0;
    end else begin
      r_mem_valid <= r_ex_valid;
      r_mem_rd    <= r_ex_rd;
      r_mem_wren  <= r_ex_wren;
      // Payload fields are don't-care when valid is low.
      r_ex_valid  <= w_load_ex;
      r_ex_rd     <= i_id_rd_addr;
      r_ex_wren   <= i_id_rd_wren;
      r_ex_load   <= i_id_is_load;
      r_forward_a <= w_load_ex ? w_fwd_a_next : 2'd0;
      r_forward_b <= w_load_ex ? w_fwd_b_next : 2'd0;
      if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end
  end

  assign o_forward_A   = r_forward_a;
  assign o_forward_B   = r_forward_b;
  assign o_stall_id    = w_stall;
  assign o_bubble_idex = w_bubble;
  assign o_flush_ifid  = i_ex_redirect;
  assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_forward_unit
//
// Directed instruction sequences with hand-computed expectations, plus a
// behavioural model that tracks the history of EX occupants and checks every
// DUT output on each falling edge. A narrow counter width exercises saturation.
// -----------------------------------------------------------------------------
module tb_hazard_forward_unit;

  localparam int AW   = 5;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          id_valid = 1'b0;
  logic [AW-1:0] rs1 = '0;
  logic [AW-1:0] rs2 = '0;
  logic          rs1_used = 1'b0;
  logic          rs2_used = 1'b0;
  logic [AW-1:0] rd = '0;
  logic          rd_wren = 1'b0;
  logic          is_load = 1'b0;
  logic          redirect = 1'b0;
  logic [1:0]    fwd_a;
  logic [1:0]    fwd_b;
  logic          stall;
  logic          bubble;
  logic          flush;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  hazard_forward_unit #(.REG_AW(AW), .CNT_W(CW)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_id_valid    (id_valid),
    .i_id_rs1_addr (rs1),
    .i_id_rs2_addr (rs2),
    .i_id_rs1_used (rs1_used),
    .i_id_rs2_used (rs2_used),
    .i_id_rd_addr  (rd),
    .i_id_rd_wren  (rd_wren),
    .i_id_is_load  (is_load),
    .i_ex_redirect (redirect),
    .o_forward_A   (fwd_a),
    .o_forward_B   (fwd_b),
    .o_stall_id    (stall),
    .o_bubble_idex (bubble),
    .o_flush_ifid  (flush),
    .o_stall_count (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One ID-stage instruction per call, driven just after the rising edge.
  task automatic drive(input string tag, input bit v, input int a1, input bit u1,
                       input int a2, input bit u2, input int d, input bit we,
                       input bit ld, input bit rdr);
    @(posedge clk);
    #1;
    id_valid = v;
    rs1      = AW'(a1);
    rs1_used = u1;
    rs2      = AW'(a2);
    rs2_used = u2;
    rd       = AW'(d);
    rd_wren  = we;
    is_load  = ld;
    redirect = rdr;
    $display("cycle %0t: ID <= %s", $time, tag);
  endtask

  task automatic nop();
    drive("nop", 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: remembers which instruction occupied EX in the current
  // cycle (h1) and the cycle before (h2). A consumer entering EX takes the
  // result of the youngest older writer of its register: one step ahead means
  // MEM (2) unless that producer is a load, two steps ahead means WB (1).
  // ---------------------------------------------------------------------------
  typedef struct {
    bit v;
    int d;
    bit we;
    bit ld;
  } ent_t;

  function automatic bit writes(input ent_t e, input int r);
    return e.v && e.we && (e.d != 0) && (e.d == r);
  endfunction

  function automatic int pick(input ent_t n1, input ent_t n2, input int r, input bit used);
    if (!used) return 0;
    if (writes(n1, r) && !n1.ld) return 2;
    if (writes(n2, r)) return 1;
    return 0;
  endfunction

  initial begin
    ent_t h1, h2, nx;
    int   efa, efb, ecnt;
    bit   luse, es, eb;
    h1 = '{0, 0, 0, 0};
    h2 = '{0, 0, 0, 0};
    efa = 0; efb = 0; ecnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        h1 = '{0, 0, 0, 0};
        h2 = '{0, 0, 0, 0};
        efa = 0; efb = 0; ecnt = 0;
        chk("m_rst_fwdA", {30'd0, fwd_a}, 0);
        chk("m_rst_fwdB", {30'd0, fwd_b}, 0);
        chk("m_rst_cnt", {29'd0, stall_cnt}, 0);
        chk("m_rst_stall", {31'd0, stall}, 0);
        chk("m_rst_flush", {31'd0, flush}, {31'd0, redirect});
      end else begin
        luse = id_valid && h1.ld &&
               ((rs1_used && writes(h1, int'(rs1))) || (rs2_used && writes(h1, int'(rs2))));
        es = luse && !redirect;
        eb = es || redirect;
        chk("m_fwdA", {30'd0, fwd_a}, efa);
        chk("m_fwdB", {30'd0, fwd_b}, efb);
        chk("m_stall", {31'd0, stall}, {31'd0, es});
        chk("m_bubble", {31'd0, bubble}, {31'd0, eb});
        chk("m_flush", {31'd0, flush}, {31'd0, redirect});
        chk("m_cnt", {29'd0, stall_cnt}, ecnt);
        // Advance to the state after the coming rising edge.
        if (id_valid && !eb) begin
          nx  = '{1, int'(rd), rd_wren, is_load};
          efa = pick(h1, h2, int'(rs1), rs1_used);
          efb = pick(h1, h2, int'(rs2), rs2_used);
        end else begin
          nx  = '{0, 0, 0, 0};
          efa = 0;
          efb = 0;
        end
        if (es && ecnt != CMAX) ecnt++;
        h2 = h1;
        h1 = nx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed sequences with literal expectations.
  // ---------------------------------------------------------------------------
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset_fwdA", {30'd0, fwd_a}, 0);
    chk("reset_fwdB", {30'd0, fwd_b}, 0);
    chk("reset_cnt", {29'd0, stall_cnt}, 0);
    chk("reset_stall", {31'd0, stall}, 0);
    chk("reset_bubble", {31'd0, bubble}, 0);

    // add x5,x1,x2 ; add x6,x5,x3 -> MEM forward on A
    drive("add x5,x1,x2", 1, 1, 1, 2, 1, 5, 1, 0, 0);
    drive("add x6,x5,x3", 1, 5, 1, 3, 1, 6, 1, 0, 0);
    nop();
    #1;
    chk("b2b_fwdA", {30'd0, fwd_a}, 2);
    chk("b2b_fwdB", {30'd0, fwd_b}, 0);
    nop(); nop();

    // add x5 ; nop ; sub x7,x3,x5 -> WB forward on B
    drive("add x5,x1,x2", 1, 1, 1, 2, 1, 5, 1, 0, 0);
    nop();
    drive("sub x7,x3,x5", 1, 3, 1, 5, 1, 7, 1, 0, 0);
    nop();
    #1;
    chk("gap_fwdA", {30'd0, fwd_a}, 0);
    chk("gap_fwdB", {30'd0, fwd_b}, 1);
    nop(); nop();

    // lw x5 ; add x6,x5,x5 -> one stall cycle then WB forward on both
    drive("lw x5,0(x1)", 1, 1, 1, 0, 0, 5, 1, 1, 0);
    drive("add x6,x5,x5", 1, 5, 1, 5, 1, 6, 1, 0, 0);
    #1;
    chk("luse_stall", {31'd0, stall}, 1);
    chk("luse_bubble", {31'd0, bubble}, 1);
    chk("luse_flush", {31'd0, flush}, 0);
    drive("add x6,x5,x5 (held)", 1, 5, 1, 5, 1, 6, 1, 0, 0);
    #1;
    chk("luse_stall_drop", {31'd0, stall}, 0);
    chk("luse_bubble_drop", {31'd0, bubble}, 0);
    nop();
    #1;
    chk("luse_fwdA", {30'd0, fwd_a}, 1);
    chk("luse_fwdB", {30'd0, fwd_b}, 1);
    chk("luse_cnt", {29'd0, stall_cnt}, 1);
    nop(); nop();

    // x0 never forwards or stalls
    drive("add x0,x1,x2", 1, 1, 1, 2, 1, 0, 1, 0, 0);
    drive("add x3,x0,x0", 1, 0, 1, 0, 1, 3, 1, 0, 0);
    nop();
    #1;
    chk("x0_fwdA", {30'd0, fwd_a}, 0);
    chk("x0_fwdB", {30'd0, fwd_b}, 0);
    drive("lw x0,0(x1)", 1, 1, 1, 0, 0, 0, 1, 1, 0);
    drive("add x4,x0,x0", 1, 0, 1, 0, 1, 4, 1, 0, 0);
    #1;
    chk("x0_load_stall", {31'd0, stall}, 0);
    nop(); nop(); nop();

    // load-use coinciding with a redirect: flush wins, no stall
    drive("lw x5,0(x1)", 1, 1, 1, 0, 0, 5, 1, 1, 0);
    drive("add x6,x5,x1 +redirect", 1, 5, 1, 1, 1, 6, 1, 0, 1);
    #1;
    chk("redir_stall", {31'd0, stall}, 0);
    chk("redir_flush", {31'd0, flush}, 1);
    chk("redir_bubble", {31'd0, bubble}, 1);
    nop();
    #1;
    chk("redir_fwdA", {30'd0, fwd_a}, 0);
    chk("redir_fwdB", {30'd0, fwd_b}, 0);
    chk("redir_cnt", {29'd0, stall_cnt}, 1);
    nop(); nop();

    // add x5 in MEM, addi x5 in EX -> younger (MEM select) wins
    drive("add x5,x1,x2", 1, 1, 1, 2, 1, 5, 1, 0, 0);
    drive("addi x5,x1,4", 1, 1, 1, 0, 0, 5, 1, 0, 0);
    drive("add x8,x5,x5", 1, 5, 1, 5, 1, 8, 1, 0, 0);
    nop();
    #1;
    chk("young_fwdA", {30'd0, fwd_a}, 2);
    chk("young_fwdB", {30'd0, fwd_b}, 2);
    nop(); nop();

    // Eight more load-use stalls: counter saturates at all-ones
    for (int i = 0; i < 8; i++) begin
      drive("lw x5,0(x1)", 1, 1, 1, 0, 0, 5, 1, 1, 0);
      drive("add x6,x5,x5", 1, 5, 1, 5, 1, 6, 1, 0, 0);
      drive("add x6,x5,x5 (held)", 1, 5, 1, 5, 1, 6, 1, 0, 0);
    end
    nop();
    #1;
    chk("cnt_saturate", {29'd0, stall_cnt}, CMAX);
    nop(); nop();

    // Asynchronous reset in the middle of a stall
    drive("lw x9,0(x1)", 1, 1, 1, 0, 0, 9, 1, 1, 0);
    drive("add x10,x9,x0", 1, 9, 1, 0, 1, 10, 1, 0, 0);
    #1;
    chk("mid_stall_before", {31'd0, stall}, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_stall", {31'd0, stall}, 0);
    chk("async_bubble", {31'd0, bubble}, 0);
    chk("async_fwdA", {30'd0, fwd_a}, 0);
    chk("async_fwdB", {30'd0, fwd_b}, 0);
    chk("async_cnt", {29'd0, stall_cnt}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("post_rst_stall", {31'd0, stall}, 0);
    nop();
    #1;
    chk("post_rst_fwdA", {30'd0, fwd_a}, 0);
    chk("post_rst_fwdB", {30'd0, fwd_b}, 0);
    nop(); nop(); nop();

    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
